// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// imem_boot_loader: packs a byte stream into instruction memory, then releases
// the core and serves its fetches.   Rev 1.0
// ============================================================================
module imem_boot_loader #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          AW          = 6,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic [31:0]   pc_i,
  output logic [31:0]   instr_o,
  output logic          core_reset_o,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   word_count
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH_WORDS);

  state_t       state_q;
  logic [1:0]   byte_idx_q;
  logic [23:0]  shift_q;
  logic [AW:0]  word_count_q;
  logic         ready_q;
  logic         done_q;
  logic         err_q;
  logic         core_rst_q;
  logic [31:0]  mem_q [DEPTH_WORDS];

  logic         accept_w;
  logic         full_w;
  logic         word_wr_w;
  logic [31:0]  word_w;

  assign accept_w  = load_valid & ready_q & (state_q == S_LOAD);
  assign full_w    = (word_count_q == DEPTH_C);
  assign word_wr_w = accept_w & ~full_w & ((byte_idx_q == 2'd3) | load_last);

  // Upper bytes stay zero for a short final word.
  always_comb begin
    word_w = 32'h0;
    case (byte_idx_q)
      2'd0:    word_w = {24'h0, load_data};
      2'd1:    word_w = {16'h0, load_data, shift_q[7:0]};
      2'd2:    word_w = {8'h0,  load_data, shift_q[15:0]};
      default: word_w = {load_data, shift_q[23:0]};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LOAD;
      byte_idx_q   <= 2'd0;
      shift_q      <= 24'h0;
      word_count_q <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_q   <= 1'b1;
    end else begin
      // Lags the state by one edge so the core sees one extra reset cycle.
      core_rst_q <= (state_q != S_RUN);
      case (state_q)
        S_LOAD: begin
          if (accept_w) begin
            if (full_w) begin
              state_q <= S_ERROR;
              ready_q <= 1'b0;
              err_q   <= 1'b1;
            end else if ((byte_idx_q == 2'd3) || load_last) begin
              word_count_q <= word_count_q + 1'b1;
              byte_idx_q   <= 2'd0;
              shift_q      <= 24'h0;
              if (load_last) begin
                state_q <= S_RUN;
                ready_q <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
              case (byte_idx_q)
                2'd0:    shift_q[7:0]   <= load_data;
                2'd1:    shift_q[15:8]  <= load_data;
                default: shift_q[23:16] <= load_data;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Contents survive reset; word_count gating hides stale words.
  always_ff @(posedge clk) begin
    if (word_wr_w) mem_q[word_count_q[AW-1:0]] <= word_w;
  end

  logic [AW-1:0] idx_w;
  logic          hi_zero_w;
  logic          pc_unused_w;

  assign idx_w       = pc_i[AW+1:2];
  assign hi_zero_w   = (pc_i[31:AW+2] == '0);
  assign pc_unused_w = ^pc_i[1:0];

  always_comb begin
    instr_o = NOP_INSTR;
    if ((state_q == S_RUN) && hi_zero_w && ({1'b0, idx_w} < word_count_q))
      instr_o = mem_q[idx_w];
  end

  assign load_ready   = ready_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign core_reset_o = core_rst_q;
  assign word_count   = word_count_q;

endmodule
`default_nettype wire
